// File: rtl/adc128s022_uart_tx_if.sv
// Request/status bundle for the ADC128S022 readout and UART back end.
// master = frame sequencer side, slave = the readout block.
interface adc128s022_uart_tx_if;
   logic        start_convert;
   logic        ADC_SDAT;
   logic        ADC_SCLK;
   logic        ADC_CS_N;
   logic        ADC_SADDR;
   logic [15:0] data_out;
   logic        TX_LAUNCH;
   logic        transmit_flg;
   logic        Tx_out;

   modport master (
      output start_convert, ADC_SDAT, TX_LAUNCH,
      input  ADC_SCLK, ADC_CS_N, ADC_SADDR,
      input  data_out, transmit_flg, Tx_out
   );

   modport slave (
      input  start_convert, ADC_SDAT, TX_LAUNCH,
      output ADC_SCLK, ADC_CS_N, ADC_SADDR,
      output data_out, transmit_flg, Tx_out
   );
endinterface

// File: rtl/adc128s022_uart_tx.sv
// ADC128S022 serial master plus 8N1 UART sending the low byte of the
// latest conversion; both halves share one clock and run independently.
module adc128s022_uart_tx #(
   parameter int         SCLK_DIV     = 25,
   parameter logic [2:0] CHANNEL      = 3'd0,
   parameter int         CLKS_PER_BIT = 434
) (
   input logic                  clk_in,
   input logic                  reset,
   adc128s022_uart_tx_if.slave  bus
);

   typedef enum logic [1:0] {A_IDLE, A_CONV, A_DONE} adc_st_e;
   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_st_e;

   localparam logic [15:0] DIV_END = 16'(SCLK_DIV - 1);
   localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);

   adc_st_e     adc_st_q, adc_st_d;
   logic [15:0] adc_t_q, adc_t_d;
   logic [5:0]  tog_q, tog_d;
   logic [15:0] sh_q, sh_d;
   logic [15:0] data_q, data_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        saddr_q, saddr_d;
   logic        sreq_q, sreq_d;
   logic        sarm_q, sarm_d;
   logic        s_acc;

   uart_st_e    u_st_q, u_st_d;
   logic [15:0] u_t_q, u_t_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  byte_q, byte_d;
   logic        tx_q, tx_d;
   logic        flg_q, flg_d;
   logic        treq_q, treq_d;
   logic        tarm_q, tarm_d;
   logic        t_acc;

   // Channel address occupies frame bits 2..4, MSB first.
   function automatic logic fbit(input logic [3:0] n);
      case (n)
         4'd2:    fbit = CHANNEL[2];
         4'd3:    fbit = CHANNEL[1];
         4'd4:    fbit = CHANNEL[0];
         default: fbit = 1'b0;
      endcase
   endfunction

   always_comb begin
      adc_st_d = adc_st_q;
      adc_t_d  = adc_t_q;
      tog_d    = tog_q;
      sh_d     = sh_q;
      data_d   = data_q;
      cs_n_d   = cs_n_q;
      sclk_d   = sclk_q;
      saddr_d  = saddr_q;
      sreq_d   = bus.start_convert;
      s_acc    = !sreq_q && sarm_q && (adc_st_q == A_IDLE);
      sarm_d   = s_acc ? 1'b0 : (sreq_q ? 1'b1 : sarm_q);
      unique case (adc_st_q)
         A_IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b1;
            if (s_acc) begin
               adc_st_d = A_CONV;
               cs_n_d   = 1'b0;
               adc_t_d  = '0;
               tog_d    = '0;
            end
         end
         A_CONV: begin
            if (adc_t_q == DIV_END) begin
               adc_t_d = '0;
               tog_d   = tog_q + 6'd1;
               sclk_d  = ~sclk_q;
               if (sclk_q) saddr_d = fbit(tog_q[4:1]);
               else        sh_d    = {sh_q[14:0], bus.ADC_SDAT};
               if (tog_q == 6'd31) adc_st_d = A_DONE;
            end else begin
               adc_t_d = adc_t_q + 16'd1;
            end
         end
         A_DONE: begin
            if (adc_t_q == DIV_END) begin
               adc_t_d  = '0;
               cs_n_d   = 1'b1;
               data_d   = sh_q;
               adc_st_d = A_IDLE;
            end else begin
               adc_t_d = adc_t_q + 16'd1;
            end
         end
         default: adc_st_d = A_IDLE;
      endcase
   end

   always_comb begin
      u_st_d  = u_st_q;
      u_t_d   = u_t_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      flg_d   = 1'b0;
      treq_d  = bus.TX_LAUNCH;
      t_acc   = !treq_q && tarm_q && (u_st_q == U_IDLE);
      tarm_d  = t_acc ? 1'b0 : (treq_q ? 1'b1 : tarm_q);
      unique case (u_st_q)
         U_IDLE: begin
            tx_d = 1'b1;
            if (t_acc) begin
               u_st_d = U_START;
               tx_d   = 1'b0;
               byte_d = data_q[7:0];
               u_t_d  = '0;
            end
         end
         U_START: begin
            if (u_t_q == BIT_END) begin
               u_t_d  = '0;
               u_st_d = U_DATA;
               bit_d  = '0;
               tx_d   = byte_q[0];
            end else begin
               u_t_d = u_t_q + 16'd1;
            end
         end
         U_DATA: begin
            if (u_t_q == BIT_END) begin
               u_t_d  = '0;
               byte_d = {1'b0, byte_q[7:1]};
               if (bit_q == 3'd7) begin
                  u_st_d = U_STOP;
                  tx_d   = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = byte_q[1];
               end
            end else begin
               u_t_d = u_t_q + 16'd1;
            end
         end
         U_STOP: begin
            if (u_t_q == BIT_END) begin
               u_t_d  = '0;
               u_st_d = U_IDLE;
               flg_d  = 1'b1;
            end else begin
               u_t_d = u_t_q + 16'd1;
            end
         end
         default: u_st_d = U_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         adc_st_q <= A_IDLE;
         adc_t_q  <= '0;
         tog_q    <= '0;
         sh_q     <= '0;
         data_q   <= '0;
         cs_n_q   <= 1'b1;
         sclk_q   <= 1'b1;
         saddr_q  <= 1'b0;
         sreq_q   <= 1'b1;
         sarm_q   <= 1'b1;
         u_st_q   <= U_IDLE;
         u_t_q    <= '0;
         bit_q    <= '0;
         byte_q   <= '0;
         tx_q     <= 1'b1;
         flg_q    <= 1'b0;
         treq_q   <= 1'b1;
         tarm_q   <= 1'b1;
      end else begin
         adc_st_q <= adc_st_d;
         adc_t_q  <= adc_t_d;
         tog_q    <= tog_d;
         sh_q     <= sh_d;
         data_q   <= data_d;
         cs_n_q   <= cs_n_d;
         sclk_q   <= sclk_d;
         saddr_q  <= saddr_d;
         sreq_q   <= sreq_d;
         sarm_q   <= sarm_d;
         u_st_q   <= u_st_d;
         u_t_q    <= u_t_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         tx_q     <= tx_d;
         flg_q    <= flg_d;
         treq_q   <= treq_d;
         tarm_q   <= tarm_d;
      end
   end

   assign bus.ADC_CS_N     = cs_n_q;
   assign bus.ADC_SCLK     = sclk_q;
   assign bus.ADC_SADDR    = saddr_q;
   assign bus.data_out     = data_q;
   assign bus.Tx_out       = tx_q;
   assign bus.transmit_flg = flg_q;

endmodule

// File: tb/tb_adc128s022_uart_tx.sv
// Scoreboard bench: stimulus queues expected ADC words and UART bytes,
// monitors decode the SPI and serial lines and compare on completion.
module tb_adc128s022_uart_tx;

   localparam int DIV = 25;
   localparam int CPB = 434;
   localparam logic [15:0] SADDR_EXP = 16'h2800;

   logic clk;
   logic reset;
   int   cyc;
   int   tests;
   int   fails;
   int   adc_done;
   int   tx_done;
   logic [15:0] adc_word;
   logic [15:0] exp_adc[$];
   logic [7:0]  exp_tx[$];

   adc128s022_uart_tx_if bus ();

   adc128s022_uart_tx #(
      .SCLK_DIV(DIV),
      .CHANNEL(3'd5),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk_in(clk),
      .reset(reset),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ADC model: shifts adc_word out MSB first on SCLK falling edges.
   initial begin
      logic ps;
      int   n;
      ps = 1'b1;
      n  = 0;
      forever begin
         @(bus.ADC_CS_N or bus.ADC_SCLK);
         if (bus.ADC_CS_N) begin
            n = 0;
         end else if (ps && !bus.ADC_SCLK && n < 16) begin
            bus.ADC_SDAT = adc_word[15-n];
            n++;
         end
         ps = bus.ADC_SCLK;
      end
   end

   initial begin : adc_mon
      logic pcs, psclk;
      int   fall_c, ntog, last_t, badper;
      logic [15:0] sa;
      logic [15:0] ew;
      pcs = 1'b1; psclk = 1'b1;
      fall_c = 0; ntog = 0; last_t = 0; badper = 0; sa = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pcs = 1'b1;
            psclk = 1'b1;
         end else begin
            if (pcs && !bus.ADC_CS_N) begin
               fall_c = cyc; ntog = 0; last_t = cyc; badper = 0; sa = '0;
            end
            if (!bus.ADC_CS_N && bus.ADC_SCLK != psclk) begin
               ntog++;
               if (cyc - last_t != DIV) badper++;
               last_t = cyc;
               if (bus.ADC_SCLK) sa = {sa[14:0], bus.ADC_SADDR};
            end
            if (!pcs && bus.ADC_CS_N) begin
               if (exp_adc.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL adc_unexpected: got frame %0h, expected none",
                           bus.data_out);
               end else begin
                  ew = exp_adc.pop_front();
                  chk("adc_data", 32'(bus.data_out), 32'(ew));
                  chk("adc_saddr", 32'(sa), 32'(SADDR_EXP));
                  chk("adc_cs_len", 32'(cyc - fall_c), 32'(33 * DIV));
                  chk("adc_toggles", 32'(ntog), 32'd32);
                  chk("adc_period_err", 32'(badper), 32'd0);
               end
               adc_done++;
            end
            pcs = bus.ADC_CS_N;
            psclk = bus.ADC_SCLK;
         end
      end
   end

   initial begin : uart_mon
      logic pt;
      logic [9:0] b;
      logic [7:0] eb;
      int st;
      pt = 1'b1;
      b  = '0;
      forever begin
         @(negedge clk);
         if (!reset && pt && !bus.Tx_out) begin
            st = cyc;
            eb = 8'h00;
            if (exp_tx.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_unexpected: got frame start, expected idle");
            end else begin
               eb = exp_tx.pop_front();
            end
            for (int i = 0; i < 10; i++) begin
               repeat ((i == 0) ? CPB / 2 : CPB) @(negedge clk);
               b[i] = bus.Tx_out;
            end
            chk("tx_start_bit", 32'(b[0]), 32'd0);
            chk("tx_byte", 32'(b[8:1]), 32'(eb));
            chk("tx_stop_bit", 32'(b[9]), 32'd1);
            for (int k = 0; k < CPB; k++) begin
               if (bus.transmit_flg) break;
               @(negedge clk);
            end
            chk("tx_flg_time", 32'(cyc - st), 32'(10 * CPB));
            chk("tx_line_at_flg", 32'(bus.Tx_out), 32'd1);
            @(negedge clk);
            chk("tx_flg_pulse", 32'(bus.transmit_flg), 32'd0);
            tx_done++;
         end
         pt = bus.Tx_out;
      end
   end

   task automatic wait_adc(input int target);
      for (int i = 0; i < 3000; i++) begin
         if (adc_done >= target) break;
         @(negedge clk);
      end
      chk("adc_wait", 32'(adc_done >= target), 32'd1);
   endtask

   task automatic wait_tx(input int target);
      for (int i = 0; i < 6000; i++) begin
         if (tx_done >= target) break;
         @(negedge clk);
      end
      chk("tx_wait", 32'(tx_done >= target), 32'd1);
   endtask

   // One-clock low pulse on start_convert, checking the 2-clock CS latency.
   task automatic pulse_start(input logic [15:0] w, input logic expect_done);
      @(negedge clk);
      adc_word = w;
      if (expect_done) exp_adc.push_back(w);
      bus.start_convert = 1'b0;
      @(posedge clk);
      #1;
      bus.start_convert = 1'b1;
      chk("adc_lat_1", 32'(bus.ADC_CS_N), 32'd1);
      @(posedge clk);
      #1;
      chk("adc_lat_2", 32'(bus.ADC_CS_N), 32'd0);
   endtask

   initial begin
      int n0, lows;
      tests = 0; fails = 0; adc_done = 0; tx_done = 0;
      adc_word = 16'h0000;
      reset = 1'b1;
      bus.start_convert = 1'b1;
      bus.TX_LAUNCH = 1'b1;
      bus.ADC_SDAT = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", 32'(bus.ADC_CS_N), 32'd1);
      chk("rst_sclk", 32'(bus.ADC_SCLK), 32'd1);
      chk("rst_saddr", 32'(bus.ADC_SADDR), 32'd0);
      chk("rst_data", 32'(bus.data_out), 32'd0);
      chk("rst_tx", 32'(bus.Tx_out), 32'd1);
      chk("rst_flg", 32'(bus.transmit_flg), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      pulse_start(16'h0A5C, 1'b1);
      wait_adc(1);

      pulse_start(16'h0FFF, 1'b0);
      repeat (300) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_cs_n", 32'(bus.ADC_CS_N), 32'd1);
      chk("mid_rst_sclk", 32'(bus.ADC_SCLK), 32'd1);
      chk("mid_rst_data", 32'(bus.data_out), 32'd0);
      chk("mid_rst_tx", 32'(bus.Tx_out), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      pulse_start(16'h0A5C, 1'b1);
      wait_adc(2);

      n0 = adc_done;
      @(negedge clk);
      adc_word = 16'h0321;
      exp_adc.push_back(16'h0321);
      bus.start_convert = 1'b0;
      repeat (2 * 33 * DIV + 100) @(negedge clk);
      chk("held_one_conv", 32'(adc_done - n0), 32'd1);
      bus.start_convert = 1'b1;
      repeat (3) @(negedge clk);
      adc_word = 16'h0A5C;
      exp_adc.push_back(16'h0A5C);
      bus.start_convert = 1'b0;
      repeat (5) @(negedge clk);
      wait_adc(n0 + 2);
      bus.start_convert = 1'b1;
      repeat (3) @(negedge clk);
      chk("data_lo_5c", 32'(bus.data_out[7:0]), 32'h5C);

      exp_tx.push_back(8'h5C);
      bus.TX_LAUNCH = 1'b0;
      @(posedge clk);
      #1;
      chk("tx_lat_1", 32'(bus.Tx_out), 32'd1);
      @(posedge clk);
      #1;
      chk("tx_lat_2", 32'(bus.Tx_out), 32'd0);
      wait_tx(1);
      lows = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!bus.Tx_out) lows++;
      end
      chk("tx_held_idle", 32'(lows), 32'd0);
      chk("tx_held_frames", 32'(tx_done), 32'd1);
      bus.TX_LAUNCH = 1'b1;
      repeat (3) @(negedge clk);

      n0 = adc_done;
      exp_tx.push_back(8'h5C);
      bus.TX_LAUNCH = 1'b0;
      repeat (2) @(negedge clk);
      bus.TX_LAUNCH = 1'b1;
      repeat (1000) @(negedge clk);
      pulse_start(16'h0BEE, 1'b1);
      wait_adc(n0 + 1);
      chk("ovl_data", 32'(bus.data_out), 32'h0BEE);
      wait_tx(2);

      repeat (10) @(negedge clk);
      chk("adc_queue_empty", 32'(exp_adc.size()), 32'd0);
      chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: got no finish, expected summary");
      $fatal(1, "timeout");
   end

endmodule
